eth_tx_arb: RTL and testbench

ETH_TX_ARB -- requirements
Module: eth_tx_arb

---
 rtl/eth_tx_arb_if.sv | 50 +++++
 rtl/eth_tx_arb.sv | 194 +++++++++++++++++++
 tb/tb_eth_tx_arb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arb_if.sv
// eth_tx_arb_if: request, frame-field and MAC handshake bundle for eth_tx_arb.
// slave = arbiter side, master = requesters plus MAC side.
interface eth_tx_arb_if;
    // requester 0/1 frame requests and header fields
    logic        req0;
    logic        req1;
    logic [10:0] len0;
    logic [10:0] len1;
    logic [47:0] dmac0;
    logic [47:0] dmac1;
    logic [15:0] type0;
    logic [15:0] type1;
    // MAC transmit-enable, watched for frame start/end
    logic        mii_tx_en;
    // MAC launch and latched frame fields
    logic        tx_go;
    logic [10:0] data_len;
    logic [47:0] des_mac;
    logic [15:0] len_type;
    // payload mux select, status and completion pulses
    logic        sel;
    logic        busy;
    logic        done0;
    logic        done1;
    logic        err;

    modport slave (
        input  req0, req1,
        input  len0, len1,
        input  dmac0, dmac1,
        input  type0, type1,
        input  mii_tx_en,
        output tx_go, data_len,
        output des_mac, len_type,
        output sel, busy,
        output done0, done1, err
    );

    modport master (
        output req0, req1,
        output len0, len1,
        output dmac0, dmac1,
        output type0, type1,
        output mii_tx_en,
        input  tx_go, data_len,
        input  des_mac, len_type,
        input  sel, busy,
        input  done0, done1, err
    );
endinterface

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: round-robin arbiter sharing one Ethernet TX MAC between two
// requesters. Ports: mii_tx_clk, rst (sync, active high), bus (slave side).
// A grant latches the winner's header fields, launches the MAC with a
// one-cycle tx_go, follows mii_tx_en through the frame, reports completion
// on done0/done1 (with err on bad length or start timeout) and then holds
// an inter-frame gap before arbitrating again.
module eth_tx_arb #(
    parameter int IFG_CYC  = 24,
    parameter int START_TO = 255
) (
    input  logic       mii_tx_clk,
    input  logic       rst,
    eth_tx_arb_if.slave bus
);

    localparam int CMAX = (IFG_CYC > START_TO) ? IFG_CYC : START_TO;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TO_LAST  = CW'(START_TO - 1);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYC - 1);
    localparam logic [10:0]   MAX_LEN  = 11'd1500;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        SEND,
        IFG
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    // last: requester granted most recently (tie goes to the other one)
    logic          last;
    logic          last_n;
    // bad: latched length check of the current grant
    logic          bad;
    logic          bad_n;

    logic          sel_q;
    logic          sel_n;
    logic [10:0]   len_q;
    logic [10:0]   len_n;
    logic [47:0]   mac_q;
    logic [47:0]   mac_n;
    logic [15:0]   typ_q;
    logic [15:0]   typ_n;

    logic          go_q;
    logic          go_n;
    logic          d0_q;
    logic          d0_n;
    logic          d1_q;
    logic          d1_n;
    logic          err_q;
    logic          err_n;

    logic          win;
    logic [10:0]   win_len;
    logic [47:0]   win_mac;
    logic [15:0]   win_typ;
    logic          len_ok;

    // winner select; the three arms are mutually exclusive
    always_comb begin
        win = 1'b0;
        unique case (1'b1)
            (bus.req0 & bus.req1):  win = ~last;
            (bus.req1 & ~bus.req0): win = 1'b1;
            default:                win = 1'b0;
        endcase
    end

    assign win_len = win ? bus.len1  : bus.len0;
    assign win_mac = win ? bus.dmac1 : bus.dmac0;
    assign win_typ = win ? bus.type1 : bus.type0;
    assign len_ok  = (win_len != 11'd0) && (win_len <= MAX_LEN);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        bad_n   = bad;
        sel_n   = sel_q;
        len_n   = len_q;
        mac_n   = mac_q;
        typ_n   = typ_q;
        go_n    = 1'b0;
        d0_n    = 1'b0;
        d1_n    = 1'b0;
        err_n   = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    state_n = LAUNCH;
                    last_n  = win;
                    sel_n   = win;
                    len_n   = win_len;
                    mac_n   = win_mac;
                    typ_n   = win_typ;
                    bad_n   = ~len_ok;
                    // pulses are registered, so they show in LAUNCH
                    go_n    = len_ok;
                    err_n   = ~len_ok;
                    d0_n    = ~len_ok & ~win;
                    d1_n    = ~len_ok & win;
                end
            end
            LAUNCH: begin
                cnt_n   = '0;
                state_n = bad ? IDLE : WAIT_START;
            end
            WAIT_START: begin
                if (bus.mii_tx_en) begin
                    state_n = SEND;
                    cnt_n   = '0;
                end else if (cnt == TO_LAST) begin
                    state_n = IFG;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    d0_n    = ~sel_q;
                    d1_n    = sel_q;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SEND: begin
                if (!bus.mii_tx_en) begin
                    state_n = IFG;
                    cnt_n   = '0;
                    d0_n    = ~sel_q;
                    d1_n    = sel_q;
                end
            end
            IFG: begin
                if (cnt == IFG_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge mii_tx_clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            bad   <= 1'b0;
            sel_q <= 1'b0;
            len_q <= '0;
            mac_q <= '0;
            typ_q <= '0;
            go_q  <= 1'b0;
            d0_q  <= 1'b0;
            d1_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            last  <= last_n;
            bad   <= bad_n;
            sel_q <= sel_n;
            len_q <= len_n;
            mac_q <= mac_n;
            typ_q <= typ_n;
            go_q  <= go_n;
            d0_q  <= d0_n;
            d1_q  <= d1_n;
            err_q <= err_n;
        end
    end

    assign bus.tx_go    = go_q;
    assign bus.data_len = len_q;
    assign bus.des_mac  = mac_q;
    assign bus.len_type = typ_q;
    assign bus.sel      = sel_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done0    = d0_q;
    assign bus.done1    = d1_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed stimulus for eth_tx_arb; expected events are
// queued at stimulus time and a negedge monitor pops and compares them.
module tb_eth_tx_arb;

    localparam int IFG = 24;
    localparam int STO = 255;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;
    logic busy_q = 1'b0;

    eth_tx_arb_if bus();

    eth_tx_arb #(
        .IFG_CYC (IFG),
        .START_TO(STO)
    ) dut (
        .mii_tx_clk(clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_RISE, EV_GO, EV_DONE, EV_IDLE} ev_k;

    typedef struct {
        string       tag;
        ev_k         kind;
        int          cyc;
        logic        who;
        logic        e;
        logic [10:0] len;
        logic [47:0] mac;
        logic [15:0] typ;
        logic        zero;
    } ev_t;

    ev_t q[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic push(input string tag, input ev_k k, input int c,
                        input logic w, input logic e,
                        input logic [10:0] l, input logic [47:0] m,
                        input logic [15:0] t, input logic z);
        ev_t v;
        v.tag  = tag;
        v.kind = k;
        v.cyc  = c;
        v.who  = w;
        v.e    = e;
        v.len  = l;
        v.mac  = m;
        v.typ  = t;
        v.zero = z;
        q.push_back(v);
    endtask

    task automatic handle(input ev_k k);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none",
                     k, cyc);
        end else begin
            e = q.pop_front();
            chk({e.tag, "_kind"}, 64'(k), 64'(e.kind));
            chk({e.tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
            case (k)
                EV_RISE: chk({e.tag, "_grant_sel"}, 64'(bus.sel), 64'(e.who));
                EV_GO: begin
                    chk({e.tag, "_sel"}, 64'(bus.sel), 64'(e.who));
                    chk({e.tag, "_data_len"}, 64'(bus.data_len), 64'(e.len));
                    chk({e.tag, "_des_mac"}, 64'(bus.des_mac), 64'(e.mac));
                    chk({e.tag, "_len_type"}, 64'(bus.len_type), 64'(e.typ));
                end
                EV_DONE: begin
                    chk({e.tag, "_done_who"}, 64'(bus.done1), 64'(e.who));
                    chk({e.tag, "_done_excl"}, 64'(bus.done0 & bus.done1), 64'(0));
                    chk({e.tag, "_err"}, 64'(bus.err), 64'(e.e));
                end
                EV_IDLE: begin
                    if (e.zero) begin
                        chk({e.tag, "_rst_mac"}, 64'(bus.des_mac), 64'(0));
                        chk({e.tag, "_rst_misc"},
                            64'({bus.sel, bus.data_len, bus.len_type, bus.tx_go,
                                 bus.done0, bus.done1, bus.err}), 64'(0));
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.busy && !busy_q) handle(EV_RISE);
            if (bus.tx_go) handle(EV_GO);
            if (bus.done0 || bus.done1) handle(EV_DONE);
            if (bus.err) chk("err_with_done", 64'(bus.done0 | bus.done1), 64'(1));
            if (!bus.busy && busy_q) handle(EV_IDLE);
        end
        busy_q = bus.busy;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic set_req(input logic w, input logic [10:0] l,
                           input logic [47:0] m, input logic [15:0] t);
        if (w) begin
            bus.req1  = 1'b1;
            bus.len1  = l;
            bus.dmac1 = m;
            bus.type1 = t;
        end else begin
            bus.req0  = 1'b1;
            bus.len0  = l;
            bus.dmac0 = m;
            bus.type0 = t;
        end
    endtask

    task automatic drop(input logic w);
        if (w) bus.req1 = 1'b0;
        else bus.req0 = 1'b0;
    endtask

    // grant lands on edge g; MAC raises tx_en 2 cycles later for ton cycles
    task automatic serve(input string tag, input logic w, input int g,
                         input logic [10:0] l, input logic [47:0] m,
                         input logic [15:0] t, input int ton, output int f);
        step_to(g - 1);
        push(tag, EV_RISE, g, w, 1'b0, '0, '0, '0, 1'b0);
        push(tag, EV_GO, g, w, 1'b0, l, m, t, 1'b0);
        step(1);
        drop(w);
        step(2);
        bus.mii_tx_en = 1'b1;
        step(ton);
        bus.mii_tx_en = 1'b0;
        f = cyc;
        push(tag, EV_DONE, f + 1, w, 1'b0, '0, '0, '0, 1'b0);
        push(tag, EV_IDLE, f + IFG + 1, w, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        int c;
        int g;
        int f;
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.len0 = '0;
        bus.len1 = '0;
        bus.dmac0 = '0;
        bus.dmac1 = '0;
        bus.type0 = '0;
        bus.type1 = '0;
        bus.mii_tx_en = 1'b0;
        step(3);

        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_tx_go", 64'(bus.tx_go), 64'(0));
        chk("reset_mac", 64'(bus.des_mac), 64'(0));
        chk("reset_misc",
            64'({bus.sel, bus.data_len, bus.len_type,
                 bus.done0, bus.done1, bus.err}), 64'(0));
        rst = 1'b0;
        mon_en = 1'b1;
        step(2);

        // single requester 0, 230-cycle frame
        c = cyc;
        set_req(1'b0, 11'd100, 48'h0011_2233_4455, 16'h0800);
        serve("single0", 1'b0, c + 1, 11'd100, 48'h0011_2233_4455,
              16'h0800, 230, f);

        // requester 1 arrives mid-IFG; grant only once IFG expires
        step_to(f + 5);
        set_req(1'b1, 11'd1, 48'hAABB_CCDD_EEFF, 16'h88B5);
        serve("ifg_wait1", 1'b1, f + IFG + 2, 11'd1, 48'hAABB_CCDD_EEFF,
              16'h88B5, 12, f);

        // reset to restore the pointer, then ties alternate 0,1,0,1
        step_to(f + IFG + 6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        c = cyc;
        set_req(1'b0, 11'd60, 48'h0200_0000_0001, 16'h86DD);
        set_req(1'b1, 11'd1500, 48'h0200_0000_0002, 16'h0806);
        serve("tie_a0", 1'b0, c + 1, 11'd60, 48'h0200_0000_0001,
              16'h86DD, 10, f);
        serve("tie_a1", 1'b1, f + IFG + 2, 11'd1500, 48'h0200_0000_0002,
              16'h0806, 10, f);
        set_req(1'b0, 11'd61, 48'h0200_0000_0003, 16'h0800);
        set_req(1'b1, 11'd62, 48'h0200_0000_0004, 16'h0801);
        serve("tie_b0", 1'b0, f + IFG + 2, 11'd61, 48'h0200_0000_0003,
              16'h0800, 10, f);
        serve("tie_b1", 1'b1, f + IFG + 2, 11'd62, 48'h0200_0000_0004,
              16'h0801, 10, f);

        // zero length on requester 1: err+done1 in LAUNCH, no tx_go
        step_to(f + IFG + 6);
        c = cyc;
        set_req(1'b1, 11'd0, 48'h0300_0000_0001, 16'h0800);
        push("len0_r1", EV_RISE, c + 1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        push("len0_r1", EV_DONE, c + 1, 1'b1, 1'b1, '0, '0, '0, 1'b0);
        push("len0_r1", EV_IDLE, c + 2, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        step(1);
        drop(1'b1);
        step(4);

        // length 1501 on requester 0: just over the limit
        c = cyc;
        set_req(1'b0, 11'd1501, 48'h0300_0000_0002, 16'h0800);
        push("len1501", EV_RISE, c + 1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        push("len1501", EV_DONE, c + 1, 1'b0, 1'b1, '0, '0, '0, 1'b0);
        push("len1501", EV_IDLE, c + 2, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1);
        drop(1'b0);
        step(4);

        // start timeout at max valid length: tx_en never rises
        c = cyc;
        g = c + 1;
        set_req(1'b0, 11'd1500, 48'h0400_0000_0001, 16'h0800);
        push("timeout", EV_RISE, g, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        push("timeout", EV_GO, g, 1'b0, 1'b0, 11'd1500,
             48'h0400_0000_0001, 16'h0800, 1'b0);
        push("timeout", EV_DONE, g + STO + 1, 1'b0, 1'b1,
             '0, '0, '0, 1'b0);
        push("timeout", EV_IDLE, g + STO + IFG + 1, 1'b0, 1'b0,
             '0, '0, '0, 1'b0);
        step(1);
        drop(1'b0);
        step_to(g + STO + IFG + 10);

        // reset in the middle of SEND: idle next edge, no done
        c = cyc;
        g = c + 1;
        set_req(1'b1, 11'd64, 48'h0500_0000_0001, 16'h0800);
        push("rst_send", EV_RISE, g, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        push("rst_send", EV_GO, g, 1'b1, 1'b0, 11'd64,
             48'h0500_0000_0001, 16'h0800, 1'b0);
        step(1);
        drop(1'b1);
        step(2);
        bus.mii_tx_en = 1'b1;
        step(8);
        rst = 1'b1;
        push("rst_send", EV_IDLE, g + 11, 1'b1, 1'b0, '0, '0, '0, 1'b1);
        step(1);
        rst = 1'b0;
        bus.mii_tx_en = 1'b0;
        step(40);

        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
